// File: rtl/sprite_mover.sv
// sprite_mover: tile-grid sprite movement engine with buffered turns, wall-ROM lookup and optional tunnel wrap.
module sprite_mover #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int ADDR_W = $clog2(COLS*ROWS),
  parameter int START_TILE = 495,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    step,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  output logic [$clog2(ROWS)-1:0] wall_addr,
  input  logic [COLS-1:0]         wall_data,
  output logic [ADDR_W-1:0]       tile,
  output logic [1:0]              dir,
  output logic                    moving,
  output logic                    step_done,
  output logic                    blocked
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  typedef enum logic [2:0] {IDLE, REQ_WAIT, REQ_EVAL, CUR_WAIT, CUR_EVAL} state_t;
  state_t state, state_nx;
  logic step_q, req_vld, cand_ok, press, free, fall, issue, mv_req, mv_cur, done, blk, nb_ok;
  logic [1:0] req_dir, snap, press_dir, nb_dir;
  logic [ADDR_W-1:0] cand, nb_tile;
  logic [RW-1:0] r, r_up, r_dn;
  logic [CW-1:0] c, c_lt, c_rt, wall_col;
  assign press = $countones({up, down, left, right}) == 1;
  assign press_dir = up ? 2'd0 : down ? 2'd1 : left ? 2'd2 : 2'd3;
  assign r = tile[ADDR_W-1:CW];
  assign c = tile[CW-1:0];
  assign r_up = r - 1'b1;
  assign r_dn = r + 1'b1;
  assign c_lt = c - 1'b1;
  assign c_rt = c + 1'b1;
  assign nb_ok = nb_dir == 2'd0 ? r != '0 : nb_dir == 2'd1 ? r != '1 :
                 nb_dir == 2'd2 ? (c != '0 || WRAP_EN) : (c != '1 || WRAP_EN);
  assign nb_tile = nb_dir == 2'd0 ? {r_up, c} : nb_dir == 2'd1 ? {r_dn, c} :
                   nb_dir == 2'd2 ? {r, c_lt} : {r, c_rt};
  // ROM rows are stored MSB-first, so column c lives at bit COLS-1-c
  assign wall_col = ~cand[CW-1:0];
  assign free = cand_ok && !wall_data[wall_col];
  always_ff @(posedge clk) state <= (reset || start) ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = !step_q ? IDLE : req_vld ? REQ_WAIT : moving ? CUR_WAIT : IDLE;
      REQ_WAIT: state_nx = REQ_EVAL;
      REQ_EVAL: state_nx = fall ? CUR_WAIT : IDLE;
      CUR_WAIT: state_nx = CUR_EVAL;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    nb_dir = (state == IDLE && req_vld) ? req_dir : dir;
    fall = state == REQ_EVAL && !free && moving && dir != snap;
    issue = (state == IDLE && step_q && (req_vld || moving)) || fall;
    mv_req = state == REQ_EVAL && free;
    mv_cur = state == CUR_EVAL && free;
    done = (state == IDLE && step_q && !req_vld && !moving) || (state == REQ_EVAL && !fall) || state == CUR_EVAL;
    blk = done && !mv_req && !mv_cur;
  end
  always_ff @(posedge clk) begin
    if (reset || start) begin
      step_q <= 1'b0;
      tile <= ADDR_W'(START_TILE);
      dir <= 2'd0;
      moving <= 1'b0;
      req_vld <= 1'b0;
      req_dir <= 2'd0;
      snap <= 2'd0;
      cand <= ADDR_W'(START_TILE);
      cand_ok <= 1'b0;
      wall_addr <= RW'(START_TILE / COLS);
      step_done <= 1'b0;
      blocked <= 1'b0;
    end else begin
      step_q <= step;
      step_done <= done;
      blocked <= blk;
      if (issue) begin
        cand <= nb_tile;
        cand_ok <= nb_ok;
        wall_addr <= nb_tile[ADDR_W-1:CW];
      end
      if (state == IDLE && step_q) snap <= req_dir;
      if (mv_req || mv_cur) begin
        tile <= cand;
        moving <= 1'b1;
      end
      if (mv_req) dir <= snap;
      if (blk) moving <= 1'b0;
      // a fresh press outranks clearing; a turn changed mid-step stays buffered
      if (press) begin
        req_dir <= press_dir;
        req_vld <= 1'b1;
      end else if (mv_req && req_dir == snap) req_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: directed and randomized checks of sprite_mover against a tile-arithmetic reference model.
module tb_sprite_mover;
  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam int AW = 10;
  logic clk = 1'b0;
  logic reset, start, step, up, down, left, right;
  logic [4:0] wall_addr, nw_addr;
  logic [COLS-1:0] wall_data, nw_data;
  logic [AW-1:0] tile, nw_tile;
  logic [1:0] dir, nw_dir;
  logic moving, step_done, blocked, nw_moving, nw_done, nw_blocked;
  bit wall [COLS*ROWS];
  int n_checks = 0;
  int n_fail = 0;
  int m_tile, m_dir, m_req, lat_got;
  bit m_mov, m_vld, m_blk;
  logic s_nw_done, s_nw_blk, s_nw_mov;
  logic [AW-1:0] s_nw_tile;

  always #5 clk = ~clk;

  sprite_mover u_dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .up(up), .down(down), .left(left), .right(right),
    .wall_addr(wall_addr), .wall_data(wall_data), .tile(tile), .dir(dir),
    .moving(moving), .step_done(step_done), .blocked(blocked)
  );

  sprite_mover #(.WRAP_EN(1'b0)) u_nw (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .up(up), .down(down), .left(left), .right(right),
    .wall_addr(nw_addr), .wall_data(nw_data), .tile(nw_tile), .dir(nw_dir),
    .moving(nw_moving), .step_done(nw_done), .blocked(nw_blocked)
  );

  // synchronous wall ROMs, one cycle read latency
  always @(posedge clk)
    for (int c = 0; c < COLS; c++) begin
      wall_data[COLS-1-c] <= wall[int'(wall_addr)*COLS+c];
      nw_data[COLS-1-c] <= wall[int'(nw_addr)*COLS+c];
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit can_go(input int t, input int d, input bit wrap, output int nt);
    int r = t / COLS;
    int c = t % COLS;
    bit ok;
    case (d)
      0: begin ok = r > 0; r = r - 1; end
      1: begin ok = r < ROWS-1; r = r + 1; end
      2: begin ok = c > 0 || wrap; c = (c + COLS - 1) % COLS; end
      default: begin ok = c < COLS-1 || wrap; c = (c + 1) % COLS; end
    endcase
    nt = r * COLS + c;
    return ok ? !wall[nt] : 1'b0;
  endfunction

  task automatic model_press(input logic [3:0] b);
    if ($countones(b) == 1) begin
      m_req = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
      m_vld = 1'b1;
    end
  endtask

  task automatic model_step(output int lat);
    int nt;
    m_blk = 1'b0;
    if (m_vld && can_go(m_tile, m_req, 1'b1, nt)) begin
      m_tile = nt; m_dir = m_req; m_mov = 1'b1; m_vld = 1'b0; lat = 3;
    end else if (m_vld && !(m_mov && m_dir != m_req)) begin
      m_mov = 1'b0; m_blk = 1'b1; lat = 3;
    end else if (m_mov) begin
      lat = m_vld ? 5 : 3;
      if (can_go(m_tile, m_dir, 1'b1, nt)) m_tile = nt;
      else begin m_mov = 1'b0; m_blk = 1'b1; end
    end else begin
      m_blk = 1'b1; lat = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m_tile = 495; m_dir = 0; m_mov = 1'b0; m_vld = 1'b0; m_blk = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk) {up, down, left, right} = b;
    @(negedge clk) {up, down, left, right} = 4'b0;
    model_press(b);
  endtask

  task automatic do_step(input logic [3:0] b, input string tag);
    int lat;
    @(negedge clk);
    {up, down, left, right} = b;
    step = 1'b1;
    model_press(b);
    model_step(lat);
    @(posedge clk);
    #1;
    step = 1'b0;
    {up, down, left, right} = 4'b0;
    lat_got = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (step_done) begin lat_got = k; break; end
    end
    s_nw_done = nw_done; s_nw_blk = nw_blocked; s_nw_mov = nw_moving; s_nw_tile = nw_tile;
    chk({tag, "/latency"}, lat_got, lat);
    chk({tag, "/tile"}, tile, m_tile);
    chk({tag, "/dir"}, dir, m_dir);
    chk({tag, "/moving"}, moving, m_mov);
    chk({tag, "/blocked"}, blocked, m_blk);
    chk({tag, "/req_vld"}, u_dut.req_vld, m_vld);
  endtask

  initial begin
    int pulses, first, lat;
    logic [3:0] b;
    reset = 1'b1; start = 1'b0; step = 1'b0;
    {up, down, left, right} = 4'b0;
    repeat (2) @(negedge clk);
    // held reset swallows steps entirely
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step = k[0];
      @(posedge clk);
      #1;
      if (step_done || blocked) pulses++;
    end
    chk("rst/pulses", pulses, 0);
    chk("rst/tile", tile, 495);
    chk("rst/dir", dir, 0);
    chk("rst/moving", moving, 0);
    chk("rst/wall_addr", wall_addr, 15);
    @(negedge clk) reset = 1'b0; step = 1'b0;
    m_tile = 495; m_dir = 0; m_mov = 1'b0; m_vld = 1'b0;
    do_step(4'b0000, "idle_step");
    chk("idle_step/lat1", lat_got, 1);
    // open map
    do_reset();
    press(4'b0001);
    do_step(4'b0000, "open_right");
    chk("open_right/tile496", tile, 496);
    do_step(4'b0000, "open_cur");
    chk("open_cur/tile497", tile, 497);
    // buffered turn
    do_reset();
    wall[463] = 1'b1;
    do_step(4'b0010, "buf_left");
    do_step(4'b0001, "buf_rev");
    do_step(4'b1000, "buf_turn");
    chk("buf_turn/tile496", tile, 496);
    chk("buf_turn/lat5", lat_got, 5);
    chk("buf_turn/req_kept", u_dut.req_vld, 1);
    do_step(4'b0000, "buf_take");
    chk("buf_take/tile464", tile, 464);
    chk("buf_take/dir0", dir, 0);
    wall[463] = 1'b0;
    // wall ahead from rest
    do_reset();
    wall[496] = 1'b1;
    do_step(4'b0001, "wall");
    chk("wall/blocked", blocked, 1);
    chk("wall/tile495", tile, 495);
    wall[496] = 1'b0;
    // tunnel wrap and its disabled counterpart
    do_reset();
    do_step(4'b0010, "wrap_lead");
    for (int i = 0; i < 14; i++) do_step(4'b0000, "wrap_walk");
    chk("wrap/at480", tile, 480);
    do_step(4'b0000, "wrap");
    chk("wrap/tile511", tile, 511);
    chk("nowrap/done", s_nw_done, 1);
    chk("nowrap/blocked", s_nw_blk, 1);
    chk("nowrap/tile480", s_nw_tile, 480);
    chk("nowrap/moving", s_nw_mov, 0);
    // two buttons leave the request alone
    do_reset();
    press(4'b0001);
    press(4'b1010);
    do_step(4'b0000, "multi");
    chk("multi/tile496", tile, 496);
    // start during REQ_WAIT aborts
    do_reset();
    do_step(4'b0001, "pre_abort");
    @(negedge clk) right = 1'b1; step = 1'b1;
    @(posedge clk); #1; right = 1'b0; step = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("abort/tile", tile, 495);
    chk("abort/moving", moving, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (step_done) pulses++;
      @(posedge clk);
      #1;
    end
    chk("abort/no_done", pulses, 0);
    m_tile = 495; m_dir = 0; m_mov = 1'b0; m_vld = 1'b0;
    // second step two cycles later is dropped
    do_reset();
    @(negedge clk) right = 1'b1; step = 1'b1;
    model_press(4'b0001);
    model_step(lat);
    @(posedge clk); #1; right = 1'b0; step = 1'b0;
    pulses = 0; first = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) step = 1'b1;
      if (k == 2) step = 1'b0;
      if (step_done) begin pulses++; if (first == 0) first = k; end
    end
    chk("drop/pulses", pulses, 1);
    chk("drop/first", first, lat);
    chk("drop/tile", tile, m_tile);
    // random map and button traffic
    for (int i = 0; i < COLS*ROWS; i++) wall[i] = $urandom_range(0, 4) == 0;
    wall[495] = 1'b0;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 9);
      int a = $urandom_range(0, 3);
      int z = (a + $urandom_range(1, 3)) % 4;
      b = 4'b0;
      if (r < 4) b[r] = 1'b1;
      else if (r >= 6) begin b[a] = 1'b1; b[z] = 1'b1; end
      if ($urandom_range(0, 3) == 0) begin
        press(b);
        do_step(4'b0000, "rand");
      end else do_step(b, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
